pipe_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Combines the hazard detector's stall request, EXE-stage taken-branch and a variable-latency data-memory handshake.
- Drives per-stage freeze and flush strobes plus the PC select.
- Sits beside the hazard/forwarding units; owns all pipeline-register enables.

---
 rtl/pipe_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: 5-stage pipeline stall/flush sequencer; define PIPE_STALL_PERF_EN for stall/flush cycle counters
module pipe_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_access_MEM,
  input  logic                 mem_ready,
  input  logic                 perf_clr,
  output logic                 mem_req,
  output logic                 freeze_PC,
  output logic                 freeze_IF_ID,
  output logic                 freeze_ID_EXE,
  output logic                 freeze_EXE_MEM,
  output logic                 flush_IF_ID,
  output logic                 flush_ID_EXE,
  output logic                 bubble_MEM_WB,
  output logic                 pc_sel,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_cycles
);
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);
  state_t     r_state, w_state_nxt;
  logic [2:0] r_flush_cnt, w_flush_cnt_nxt;
  logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
  logic       r_mem_timeout, w_mem_timeout_nxt;
  logic       w_mem_stall;
  assign w_mem_stall = mem_access_MEM & ~mem_ready;
  assign mem_timeout = r_mem_timeout;
  // state and sequencing counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_flush_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
    end
  end
  // next state and Mealy strobes; reset forces NOPs into the pipe without waiting for a clock
  always_comb begin
    w_state_nxt       = r_state;
    w_flush_cnt_nxt   = r_flush_cnt;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_timeout_nxt = 1'b0;
    mem_req           = 1'b0;
    freeze_PC         = 1'b0;
    freeze_IF_ID      = 1'b0;
    freeze_ID_EXE     = 1'b0;
    freeze_EXE_MEM    = 1'b0;
    flush_IF_ID       = 1'b0;
    flush_ID_EXE      = 1'b0;
    bubble_MEM_WB     = 1'b0;
    pc_sel            = 1'b0;
    if (!rst) begin
      flush_IF_ID   = 1'b1;
      flush_ID_EXE  = 1'b1;
      bubble_MEM_WB = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          mem_req = mem_access_MEM;
          if (w_mem_stall) begin
            {freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM, bubble_MEM_WB} = '1;
            w_wait_cnt_nxt = 8'd1;
            w_state_nxt    = MEM_WAIT;
          end else if (branch_taken) begin
            pc_sel       = 1'b1;
            flush_IF_ID  = 1'b1;
            flush_ID_EXE = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_flush_cnt_nxt = FLUSH_INIT;
              w_state_nxt     = FLUSH;
            end
          end else if (hazard_detected) begin
            freeze_PC    = 1'b1;
            freeze_IF_ID = 1'b1;
            flush_ID_EXE = 1'b1;
          end
        end
        FLUSH: begin
          mem_req      = mem_access_MEM;
          flush_IF_ID  = 1'b1;
          flush_ID_EXE = 1'b1;
          if (w_mem_stall) begin
            {freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM, bubble_MEM_WB} = '1;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            w_state_nxt     = (r_flush_cnt == 3'd1) ? RUN : FLUSH;
          end
        end
        MEM_WAIT: begin
          mem_req = mem_access_MEM;
          if (!mem_access_MEM || mem_ready) begin
            w_state_nxt = RUN;
          end else begin
            {freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM, bubble_MEM_WB} = '1;
            if (r_wait_cnt == TIMEOUT) begin
              w_mem_timeout_nxt = 1'b1;
              w_state_nxt       = RUN;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end
`ifdef PIPE_STALL_PERF_EN
  logic [CNT_WIDTH-1:0] r_stall_cycles, r_flush_cycles;
  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
  // saturating stall/flush cycle counters, clear beats increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (freeze_PC && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (flush_IF_ID && !(&r_flush_cycles)) r_flush_cycles <= r_flush_cycles + 1'b1;
    end
  end
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr = perf_clr;
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of pipe_stall_ctrl against a cycle-level reference model
module tb_pipe_stall_ctrl;
  localparam int FC = 2;
  localparam int MT = 4;
  localparam int CW = 16;
  typedef struct packed {logic req, fpc, fif, fid, fex, flif, flid, bub, pc, to;} out_t;
  localparam out_t IDLE   = 10'b0000000000;
  localparam out_t RSTV   = 10'b0000011100;
  localparam out_t HAZ    = 10'b0110001000;
  localparam out_t BRN    = 10'b0000011010;
  localparam out_t FLS    = 10'b0000011000;
  localparam out_t MSTALL = 10'b1111100100;
  localparam out_t MRDY   = 10'b1000000000;
  localparam out_t TOUT   = 10'b0000000001;
  localparam out_t FLSTL  = 10'b1111111100;
  localparam out_t FLRDY  = 10'b1000011000;
  logic clk = 1'b0, rst = 1'b1;
  logic hazard_detected = 1'b0, branch_taken = 1'b0, mem_access_MEM = 1'b0, mem_ready = 1'b0, perf_clr = 1'b0;
  logic mem_req, freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM;
  logic flush_IF_ID, flush_ID_EXE, bubble_MEM_WB, pc_sel, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_cycles;
  out_t w_out;
  int checks = 0, errors = 0;
  pipe_stall_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_access_MEM(mem_access_MEM), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .mem_req(mem_req), .freeze_PC(freeze_PC), .freeze_IF_ID(freeze_IF_ID),
    .freeze_ID_EXE(freeze_ID_EXE), .freeze_EXE_MEM(freeze_EXE_MEM), .flush_IF_ID(flush_IF_ID),
    .flush_ID_EXE(flush_ID_EXE), .bubble_MEM_WB(bubble_MEM_WB), .pc_sel(pc_sel),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );
  assign w_out = {mem_req, freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM,
                  flush_IF_ID, flush_ID_EXE, bubble_MEM_WB, pc_sel, mem_timeout};
  always #5 clk = ~clk;
  // reference model: waiting = cycles spent waiting on memory (0 = not waiting), flush_left = extra flush cycles owed
  int m_wait = 0, m_fl = 0, n_wait = 0, n_fl = 0;
  bit m_to = 1'b0, n_to = 1'b0;
  logic [CW-1:0] m_stall = '0, m_flush = '0;
  out_t e = '0;
  always @(negedge clk) begin
    automatic logic stall = mem_access_MEM & ~mem_ready;
    e = '0;
    n_wait = 0;
    n_fl = m_fl;
    n_to = 1'b0;
    if (!rst) begin
      e = RSTV;
    end else if (m_wait > 0) begin
      e.req = mem_access_MEM;
      if (stall) begin
        {e.fpc, e.fif, e.fid, e.fex, e.bub} = '1;
        if (m_wait == MT) n_to = 1'b1;
        else n_wait = m_wait + 1;
      end
    end else if (m_fl > 0) begin
      e.req = mem_access_MEM;
      e.flif = 1'b1;
      e.flid = 1'b1;
      if (stall) {e.fpc, e.fif, e.fid, e.fex, e.bub} = '1;
      else n_fl = m_fl - 1;
    end else begin
      e.req = mem_access_MEM;
      if (stall) begin
        {e.fpc, e.fif, e.fid, e.fex, e.bub} = '1;
        n_wait = 1;
      end else if (branch_taken) begin
        e.pc = 1'b1;
        e.flif = 1'b1;
        e.flid = 1'b1;
        n_fl = FC - 1;
      end else if (hazard_detected) begin
        e.fpc = 1'b1;
        e.fif = 1'b1;
        e.flid = 1'b1;
      end
    end
    if (rst) e.to = m_to;
    checks++;
    if (w_out !== e || stall_cycles !== m_stall || flush_cycles !== m_flush) begin
      errors++;
      $display("FAIL model t=%0t got %b/%0d/%0d want %b/%0d/%0d", $time, w_out, stall_cycles,
               flush_cycles, e, m_stall, m_flush);
    end
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wait <= 0;
      m_fl <= 0;
      m_to <= 1'b0;
      m_stall <= '0;
      m_flush <= '0;
    end else begin
      m_wait <= n_wait;
      m_fl <= n_fl;
      m_to <= n_to;
`ifdef PIPE_STALL_PERF_EN
      if (perf_clr) begin
        m_stall <= '0;
        m_flush <= '0;
      end else begin
        if (e.fpc && m_stall != '1) m_stall <= m_stall + 1'b1;
        if (e.flif && m_flush != '1) m_flush <= m_flush + 1'b1;
      end
`endif
    end
  end
  task automatic tick(input logic h, b, ma, mr);
    @(posedge clk);
    #1;
    hazard_detected = h;
    branch_taken = b;
    mem_access_MEM = ma;
    mem_ready = mr;
    perf_clr = 1'b0;
  endtask
  task automatic chk(input out_t v, input string nm);
    @(negedge clk);
    #1;
    checks++;
    if (w_out !== v) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, w_out, v);
    end
  endtask
  task automatic chk_cnt(input logic [CW-1:0] got, input logic [CW-1:0] want, input string nm);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask
  initial begin
    #2 rst = 1'b0;
    #1;
    checks++;
    if (w_out !== RSTV) begin
      errors++;
      $display("FAIL reset got %b want %b", w_out, RSTV);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk(IDLE, "idle");
    tick(1, 0, 0, 0); chk(HAZ, "load_use");
    tick(0, 0, 0, 0); chk(IDLE, "load_use_release");
    tick(0, 1, 0, 0); chk(BRN, "branch");
    tick(1, 0, 0, 0); chk(FLS, "flush2_hazard_ignored");
    tick(0, 0, 0, 0); chk(IDLE, "branch_done");
    tick(1, 1, 0, 0); chk(BRN, "branch_over_hazard");
    tick(0, 0, 0, 0); chk(FLS, "flush2_b");
    tick(0, 0, 1, 1); chk(MRDY, "zero_wait_mem");
    tick(0, 0, 1, 0); chk(MSTALL, "mem_entry");
    tick(0, 0, 1, 0); chk(MSTALL, "mem_wait1");
    tick(0, 0, 1, 0); chk(MSTALL, "mem_wait2");
    tick(0, 0, 1, 1); chk(MRDY, "mem_ready");
    tick(0, 0, 0, 0); chk(IDLE, "mem_done");
    tick(1, 1, 1, 0); chk(MSTALL, "all_mem_priority");
    tick(1, 1, 1, 1); chk(MRDY, "all_mem_ready");
    tick(1, 1, 0, 0); chk(BRN, "all_branch_replay");
    tick(0, 0, 0, 0); chk(FLS, "all_flush2");
    tick(0, 1, 0, 0); chk(BRN, "branch_then_mem");
    tick(0, 0, 1, 0); chk(FLSTL, "flush_mem_stall");
    tick(0, 0, 1, 1); chk(FLRDY, "flush_mem_ready");
    tick(0, 0, 0, 0); chk(IDLE, "flush_mem_done");
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 0); chk(MSTALL, "timeout_wait");
    end
    tick(0, 0, 0, 0); chk(TOUT, "timeout_pulse");
    tick(0, 0, 0, 0); chk(IDLE, "timeout_single");
    tick(0, 0, 1, 0); chk(MSTALL, "abandon_entry");
    tick(0, 0, 1, 0); chk(MSTALL, "abandon_wait");
    tick(0, 0, 0, 0); chk(IDLE, "abandon_drop");
    tick(1, 0, 0, 0); chk(HAZ, "abandon_back_in_run");
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0); chk(IDLE, "abandon_no_pulse");
    end
    tick(0, 0, 0, 0);
    perf_clr = 1'b1;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    @(negedge clk);
    #1;
`ifdef PIPE_STALL_PERF_EN
    chk_cnt(stall_cycles, 16'd3, "stall_cycles_3");
`else
    chk_cnt(stall_cycles, 16'd0, "stall_cycles_off");
`endif
    tick(0, 0, 0, 0);
    perf_clr = 1'b1;
    tick(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_cnt(stall_cycles, 16'd0, "stall_cycles_clr");
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (w_out !== RSTV) begin
      errors++;
      $display("FAIL async_reset got %b want %b", w_out, RSTV);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    mem_access_MEM = 1'b0;
    chk(IDLE, "after_reset");
    tick(0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
